// File: rtl/register_file_if.sv
// Register-file port bundle: two write ports, two read ports, status outputs.
interface register_file_if;
  logic [1:0]  write;
  logic [31:0] wr1;
  logic [4:0]  wa1;
  logic [31:0] wr2;
  logic [4:0]  wa2;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        re;
  logic [31:0] r1;
  logic [31:0] r2;
  logic        werr;
  logic [15:0] wcnt;

  modport master (
    output write, wr1, wa1, wr2, wa2, ra1, ra2, re,
    input  r1, r2, werr, wcnt
  );

  modport slave (
    input  write, wr1, wa1, wr2, wa2, ra1, ra2, re,
    output r1, r2, werr, wcnt
  );
endinterface

// File: rtl/register_file.sv
// 32x32 register file with two write ports, two registered read ports and
// write-through bypass, sticky illegal-encoding flag and saturating write count.
module register_file (
  input  logic           clk,
  input  logic           rst,
  register_file_if.slave bus
);

  localparam int unsigned DEPTH = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 16;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] r1_q;
  logic [DW-1:0] r2_q;
  logic          werr_q;
  logic [CW-1:0] wcnt_q;

  logic          we1_c;
  logic          we2_c;
  logic          bad_c;
  logic [1:0]    inc_c;
  logic [CW:0]   sum_c;
  logic [CW-1:0] wcnt_nxt_c;
  logic [DW-1:0] rd1_c;
  logic [DW-1:0] rd2_c;

  // Decode write encoding and compute the saturating count update.
  always_comb begin
    we1_c = 1'b0;
    we2_c = 1'b0;
    bad_c = 1'b0;
    case (bus.write)
      2'b01:   we1_c = 1'b1;
      2'b11: begin
        we1_c = 1'b1;
        we2_c = 1'b1;
      end
      2'b10:   bad_c = 1'b1;
      default: ;
    endcase

    inc_c = 2'd0;
    if (we2_c)      inc_c = (bus.wa1 == bus.wa2) ? 2'd1 : 2'd2;
    else if (we1_c) inc_c = 2'd1;

    sum_c      = 17'(wcnt_q) + 17'(inc_c);
    wcnt_nxt_c = sum_c[CW] ? {CW{1'b1}} : sum_c[CW-1:0];
  end

  // Read muxes with bypass: port-2 write data beats port-1, which beats storage.
  always_comb begin
    rd1_c = mem[bus.ra1];
    if (we2_c && (bus.wa2 == bus.ra1))      rd1_c = bus.wr2;
    else if (we1_c && (bus.wa1 == bus.ra1)) rd1_c = bus.wr1;

    rd2_c = mem[bus.ra2];
    if (we2_c && (bus.wa2 == bus.ra2))      rd2_c = bus.wr2;
    else if (we1_c && (bus.wa1 == bus.ra2)) rd2_c = bus.wr1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      r1_q   <= '0;
      r2_q   <= '0;
      werr_q <= 1'b0;
      wcnt_q <= '0;
    end else begin
      // Port 2 is assigned last so it wins when both ports hit one entry.
      if (we1_c) mem[bus.wa1] <= bus.wr1;
      if (we2_c) mem[bus.wa2] <= bus.wr2;
      if (bus.re) begin
        r1_q <= rd1_c;
        r2_q <= rd2_c;
      end
      if (bad_c) werr_q <= 1'b1;
      wcnt_q <= wcnt_nxt_c;
    end
  end

  assign bus.r1   = r1_q;
  assign bus.r2   = r2_q;
  assign bus.werr = werr_q;
  assign bus.wcnt = wcnt_q;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: array-based reference model checked every
// cycle, plus literal expectations at key points of the sequence.
module tb_register_file;

  logic clk;
  logic rst;
  register_file_if bus ();

  register_file dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] m_mem [32];
  logic [31:0] m_r1;
  logic [31:0] m_r2;
  logic        m_werr;
  int          m_cnt;
  logic        model_valid;

  int n_chk;
  int n_pass;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // One clock of stimulus; the model then applies the same cycle's rules.
  task automatic apply(input logic r, input logic [1:0] w,
                       input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] a2, input logic [31:0] d2,
                       input logic rden, input logic [4:0] q1, input logic [4:0] q2);
    rst       = r;
    bus.write = w;
    bus.wa1   = a1;
    bus.wr1   = d1;
    bus.wa2   = a2;
    bus.wr2   = d2;
    bus.re    = rden;
    bus.ra1   = q1;
    bus.ra2   = q2;
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      m_r1   = '0;
      m_r2   = '0;
      m_werr = 1'b0;
      m_cnt  = 0;
    end else begin
      if (w == 2'b01) begin
        m_mem[a1] = d1;
        m_cnt     = m_cnt + 1;
      end else if (w == 2'b11) begin
        m_mem[a1] = d1;
        m_mem[a2] = d2;
        m_cnt     = m_cnt + ((a1 == a2) ? 1 : 2);
      end else if (w == 2'b10) begin
        m_werr = 1'b1;
      end
      if (m_cnt > 65535) m_cnt = 65535;
      if (rden) begin
        m_r1 = m_mem[q1];
        m_r2 = m_mem[q2];
      end
    end
    model_valid = 1'b1;
    #2;
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      chk("r1", bus.r1, m_r1);
      chk("r2", bus.r2, m_r2);
      chk("werr", 32'(bus.werr), 32'(m_werr));
      chk("wcnt", 32'(bus.wcnt), 32'(m_cnt));
    end
  end

  initial begin
    n_chk       = 0;
    n_pass      = 0;
    model_valid = 1'b0;

    // Reset while a dual write is presented: nothing may survive.
    apply(1'b0, 2'b11, 5'd5, 32'hAAAA_AAAA, 5'd6, 32'hBBBB_BBBB, 1'b1, 5'd5, 5'd6);
    chk("rst_r1", bus.r1, 32'h0);

    apply(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd31);
    chk("init_r1", bus.r1, 32'h0);
    chk("init_r2", bus.r2, 32'h0);
    chk("init_werr", 32'(bus.werr), 32'h0);
    chk("init_wcnt", 32'(bus.wcnt), 32'h0);

    // Port-1 write with same-cycle read of that address.
    apply(1'b1, 2'b01, 5'd3, 32'hDEAD_BEEF, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0);
    chk("byp1_r1", bus.r1, 32'hDEAD_BEEF);
    apply(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0);
    chk("rd3_r1", bus.r1, 32'hDEAD_BEEF);
    chk("rd3_wcnt", 32'(bus.wcnt), 32'd1);

    // Dual write to the same entry: port 2 wins, counts once.
    apply(1'b1, 2'b11, 5'd7, 32'd1, 5'd7, 32'd2, 1'b0, 5'd0, 5'd0);
    chk("same_hold_r1", bus.r1, 32'hDEAD_BEEF);
    apply(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0);
    chk("same_r1", bus.r1, 32'd2);
    chk("same_wcnt", 32'(bus.wcnt), 32'd2);

    // Dual write to distinct entries with bypass on both read ports.
    apply(1'b1, 2'b11, 5'd4, 32'd10, 5'd9, 32'd20, 1'b1, 5'd4, 5'd9);
    chk("dual_r1", bus.r1, 32'd10);
    chk("dual_r2", bus.r2, 32'd20);
    chk("dual_wcnt", 32'(bus.wcnt), 32'd4);

    // re=0 holds outputs while the write still commits.
    apply(1'b1, 2'b01, 5'd4, 32'd99, 5'd0, 32'h0, 1'b0, 5'd4, 5'd9);
    chk("hold_r1", bus.r1, 32'd10);
    chk("hold_wcnt", 32'(bus.wcnt), 32'd5);

    // Illegal encoding: no write, no bypass, sticky error.
    apply(1'b1, 2'b10, 5'd0, 32'h0, 5'd1, 32'd55, 1'b1, 5'd1, 5'd4);
    chk("ill_r1", bus.r1, 32'h0);
    chk("ill_r2", bus.r2, 32'd99);
    chk("ill_werr", 32'(bus.werr), 32'h1);
    chk("ill_wcnt", 32'(bus.wcnt), 32'd5);
    apply(1'b1, 2'b01, 5'd2, 32'd5, 5'd0, 32'h0, 1'b1, 5'd2, 5'd1);
    chk("sticky_werr", 32'(bus.werr), 32'h1);
    chk("sticky_r2", bus.r2, 32'h0);
    chk("sticky_wcnt", 32'(bus.wcnt), 32'd6);

    // Drive the counter up to FFFE with dual distinct writes.
    for (int i = 0; i < 32764; i++)
      apply(1'b1, 2'b11, 5'd10, 32'(i), 5'd11, ~32'(i), 1'b1, 5'd10, 5'd11);
    chk("pre_wcnt", 32'(bus.wcnt), 32'h0000_FFFE);
    chk("pre_r1", bus.r1, 32'd32763);

    apply(1'b1, 2'b11, 5'd12, 32'h123, 5'd13, 32'h456, 1'b1, 5'd12, 5'd13);
    chk("sat_wcnt", 32'(bus.wcnt), 32'h0000_FFFF);
    chk("sat_r1", bus.r1, 32'h123);
    chk("sat_r2", bus.r2, 32'h456);
    apply(1'b1, 2'b01, 5'd14, 32'd7, 5'd0, 32'h0, 1'b1, 5'd14, 5'd4);
    chk("sat2_wcnt", 32'(bus.wcnt), 32'h0000_FFFF);
    chk("sat2_r2", bus.r2, 32'd99);
    chk("sat2_werr", 32'(bus.werr), 32'h1);

    // Reset during a dual write clears everything.
    apply(1'b0, 2'b11, 5'd5, 32'hAAAA_AAAA, 5'd6, 32'hBBBB_BBBB, 1'b1, 5'd5, 5'd6);
    chk("rst2_r1", bus.r1, 32'h0);
    chk("rst2_werr", 32'(bus.werr), 32'h0);
    chk("rst2_wcnt", 32'(bus.wcnt), 32'h0);
    apply(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd5);
    chk("post_r1", bus.r1, 32'h0);
    chk("post_r2", bus.r2, 32'h0);
    apply(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd14, 5'd6);
    chk("post2_r1", bus.r1, 32'h0);
    chk("post2_r2", bus.r2, 32'h0);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001: Parameters: none; fixed 32 entries x 32 bits, 5-bit addresses.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst  input  1  reset, synchronous, active-low (0 = reset), sampled on rising clk.
REQ-004: write  input  2  write-port enables from writeback: bit0 = port 1, bit1 = port 2.
REQ-005: wr1  input  32  port-1 write data.
REQ-006: wa1  input  5  port-1 write address.
REQ-007: wr2  input  32  port-2 write data.
REQ-008: wa2  input  5  port-2 write address.
REQ-009: ra1  input  5  read-port-1 address.
REQ-010: ra2  input  5  read-port-2 address.
REQ-011: re  input  1  read enable; 0 = r1/r2 hold their previous values.
REQ-012: r1  output  32  read-port-1 data, registered.
REQ-013: r2  output  32  read-port-2 data, registered.
REQ-014: werr  output  1  sticky error flag: illegal write encoding seen.
REQ-015: wcnt  output  16  count of register writes committed, saturating.

Function
REQ-016: Storage: 32 x 32-bit registers; entry 0 is an ordinary writable register.
REQ-017: write=00: no storage update.
REQ-018: write=01: mem[wa1] <= wr1 at the clk edge.
REQ-019: write=11: mem[wa1] <= wr1 and mem[wa2] <= wr2 at the same edge.
REQ-020: write=11 with wa1==wa2: port 2 wins; mem[wa2] <= wr2 and wr1 is discarded.
REQ-021: write=10: illegal encoding; no storage update; werr <= 1 and holds until reset.
REQ-022: Read latency is 1 cycle: with re=1 at edge N, r1/r2 show the addressed data after edge N.
REQ-023: Bypass: if a write commits at the same edge as a read of the same address, r1/r2 return the newly written value, not the old one.
REQ-024: Bypass priority follows REQ-020: port-2 data over port-1 data over stored data.
REQ-025: Bypass applies only to committed writes; write=10 never bypasses.
REQ-026: re=0: r1/r2 hold; writes still commit.
REQ-027: wcnt increments by 1 for write=01, by 2 for write=11 with distinct addresses, and by 1 for write=11 with equal addresses; it does not increment for 00 or 10.
REQ-028: wcnt saturates at 16'hFFFF and never wraps.
REQ-029: All outputs come from registers; no combinational path from inputs to outputs.

Reset
REQ-030: When rst=0 at an edge: all 32 entries <= 0, r1 <= 0, r2 <= 0, werr <= 0, wcnt <= 0.
REQ-031: Reset overrides any write, read, or error in the same cycle; no write from that cycle survives.
REQ-032: The first edge with rst=1 behaves as normal operation; there are no extra idle cycles.

Verification
REQ-033: Reset, then re=1 with ra1=5 and ra2=31 -> r1=0 and r2=0; werr=0; wcnt=0.
REQ-034: write=01, wa1=3, wr1=32'hDEADBEEF, re=1, ra1=3 in the same cycle -> r1=DEADBEEF after that edge (bypass); next cycle re=1, ra1=3 -> r1=DEADBEEF; wcnt=1.
REQ-035: write=11, wa1=wa2=7, wr1=1, wr2=2, then read ra1=7 -> r1=2; wcnt increments by 1.
REQ-036: write=11, wa1=4, wr1=10, wa2=9, wr2=20, with ra1=4 and ra2=9 in the same cycle -> r1=10 and r2=20; wcnt increments by 2.
REQ-037: write=10, wa2=1, wr2=55 -> mem[1] unchanged (reads 0); werr=1 and stays 1 across later legal writes until rst=0.
REQ-038: Preload wcnt to 16'hFFFE via writes, then apply write=11 with distinct addresses -> wcnt=FFFF; a further write leaves it at FFFF; assert rst=0 during a write=11 -> all state 0 afterwards.
